// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m: SQI (quad-SPI) serial SRAM responder.
// It decodes READ/WRITE commands clocked in on sck by the core and returns
// read data in sequential mode. The address auto-increments and wraps at DEPTH.
module idli_sqi_mem_m #(
  parameter int          ADDR_W    = 8,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter logic [7:0]  CMD_WRITE = 8'h02
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst,
  input  logic       i_mem_sck,
  input  logic       i_mem_cs,
  input  logic [3:0] i_mem_sio,
  output logic [3:0] o_mem_sio,
  output logic       o_mem_sio_oe,
  output logic       o_mem_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  // The shift register must hold a full opcode and the kept address bits.
  localparam int SH_W  = (ADDR_W > 8) ? ADDR_W : 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

  state_t            state_q, state_d;
  logic              sck_q;
  logic [2:0]        cnt_q, cnt_d;
  logic [SH_W-1:0]   shift_q, shift_d;
  logic [SH_W-1:0]   shift_in;
  logic              is_read_q, is_read_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        sio_q, sio_d;
  logic              oe_q, oe_d;
  logic [3:0]        wr_hi_q, wr_hi_d;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic [7:0]        rd_byte;
  logic              sck_rise, sck_fall;
  logic [7:0]        mem_q [DEPTH];

  // The oldest nibble falls off the top of the shift register; it is never needed.
  logic unused_shift_top;
  assign unused_shift_top = ^shift_q[SH_W-1:SH_W-4];

  // Edges count only inside a cs window.
  assign sck_rise = !sck_q &&  i_mem_sck && !i_mem_cs;
  assign sck_fall =  sck_q && !i_mem_sck && !i_mem_cs;
  assign shift_in = {shift_q[SH_W-5:0], i_mem_sio};
  assign rd_byte  = mem_q[addr_q];

  // Next-state, datapath and write-strobe logic; cs high overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    is_read_d = is_read_q;
    addr_d    = addr_q;
    sio_d     = sio_q;
    oe_d      = oe_q;
    wr_hi_d   = wr_hi_q;
    wr_en     = 1'b0;
    wr_data   = {wr_hi_q, i_mem_sio};

    if (i_mem_cs) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = 3'd0;
        end
        ST_CMD: begin
          if (sck_rise) begin
            shift_d = shift_in;
            if (cnt_q == 3'd1) begin
              cnt_d = 3'd0;
              if (shift_in[7:0] == CMD_READ) begin
                is_read_d = 1'b1;
                state_d   = ST_ADDR;
              end else if (shift_in[7:0] == CMD_WRITE) begin
                is_read_d = 1'b0;
                state_d   = ST_ADDR;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_ADDR: begin
          if (sck_rise) begin
            shift_d = shift_in;
            if (cnt_q == 3'd5) begin
              cnt_d   = 3'd0;
              addr_d  = shift_in[ADDR_W-1:0];
              state_d = is_read_q ? ST_DUMMY : ST_WDATA;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_DUMMY: begin
          if (sck_rise) begin
            if (cnt_q == 3'd1) begin
              cnt_d   = 3'd0;
              state_d = ST_RDATA;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_RDATA: begin
          if (sck_fall) begin
            oe_d = 1'b1;
            if (cnt_q == 3'd0) begin
              sio_d = rd_byte[7:4];
              cnt_d = 3'd1;
            end else begin
              sio_d  = rd_byte[3:0];
              cnt_d  = 3'd0;
              addr_d = addr_q + 1'b1;
            end
          end
        end
        ST_WDATA: begin
          if (sck_rise) begin
            if (cnt_q == 3'd0) begin
              wr_hi_d = i_mem_sio;
              cnt_d   = 3'd1;
            end else begin
              wr_en  = 1'b1;
              cnt_d  = 3'd0;
              addr_d = addr_q + 1'b1;
            end
          end
        end
        ST_IGNORE: begin
          oe_d = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  // Control and datapath registers.
  always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
    if (i_mem_rst) begin
      state_q   <= ST_IDLE;
      sck_q     <= 1'b0;
      cnt_q     <= 3'd0;
      shift_q   <= '0;
      is_read_q <= 1'b0;
      addr_q    <= '0;
      sio_q     <= 4'h0;
      oe_q      <= 1'b0;
      wr_hi_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      sck_q     <= i_mem_sck;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      is_read_q <= is_read_d;
      addr_q    <= addr_d;
      sio_q     <= sio_d;
      oe_q      <= oe_d;
      wr_hi_q   <= wr_hi_d;
    end
  end

  // Byte array. It is cleared by reset, so it is built from flops.
  always_ff @(posedge i_mem_gck or posedge i_mem_rst) begin
    if (i_mem_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_q[addr_q] <= wr_data;
    end
  end

  assign o_mem_sio    = sio_q;
  assign o_mem_sio_oe = oe_q;
  assign o_mem_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Testbench for idli_sqi_mem_m: it plays the core side of the SQI link.
// Randomised transactions are checked against a flat byte-array model.
module tb_idli_sqi_mem_m;

  logic       gck = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs  = 1'b1;
  logic [3:0] sio_in = 4'h0;
  logic [3:0] sio_out;
  logic       sio_oe;
  logic       busy;

  int vectors    = 0;
  int miscompares = 0;
  int ph         = 3;      // gck cycles per sck phase

  logic [7:0] ref_mem [256];
  logic [7:0] wq [$];

  idli_sqi_mem_m #(.ADDR_W(8), .CMD_READ(8'h03), .CMD_WRITE(8'h02)) dut (
    .i_mem_gck    (gck),
    .i_mem_rst    (rst),
    .i_mem_sck    (sck),
    .i_mem_cs     (cs),
    .i_mem_sio    (sio_in),
    .o_mem_sio    (sio_out),
    .o_mem_sio_oe (sio_oe),
    .o_mem_busy   (busy)
  );

  always #5 gck = ~gck;

  initial begin
    #3000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // One sck period: drive a nibble while low, sample the responder just before the rise.
  task automatic nib(input logic [3:0] d, output logic [3:0] q, output logic oe);
    sck    = 1'b0;
    sio_in = d;
    repeat (ph) @(negedge gck);
    q   = sio_out;
    oe  = sio_oe;
    sck = 1'b1;
    repeat (ph) @(negedge gck);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] q;
    logic       oe;
    nib(b[7:4], q, oe);
    nib(b[3:0], q, oe);
  endtask

  task automatic txn_start();
    sck = 1'b0;
    cs  = 1'b0;
    repeat (2) @(negedge gck);
    chk("busy_start", {7'd0, busy}, 8'h01);
  endtask

  task automatic txn_end();
    sck = 1'b0;
    cs  = 1'b1;
    repeat (2) @(negedge gck);
    chk("busy_end", {7'd0, busy}, 8'h00);
    chk("oe_end", {7'd0, sio_oe}, 8'h00);
  endtask

  task automatic send_addr(input logic [23:0] a);
    send_byte(a[23:16]);
    send_byte(a[15:8]);
    send_byte(a[7:0]);
  endtask

  // Write every byte queued in wq from address a and update the model.
  task automatic do_write(input logic [23:0] a);
    logic [7:0] idx;
    txn_start();
    send_byte(8'h02);
    send_addr(a);
    for (int i = 0; i < wq.size(); i++) begin
      send_byte(wq[i]);
      idx = a[7:0] + 8'(i);
      ref_mem[idx] = wq[i];
    end
    txn_end();
    $display("write addr=%06h bytes=%0d", a, wq.size());
  endtask

  // Read n bytes from address a and compare every one with the model.
  task automatic do_read(input logic [23:0] a, input int n);
    logic [3:0] hi, lo, q;
    logic       oe_h, oe_l, oe;
    logic [7:0] idx;
    txn_start();
    send_byte(8'h03);
    send_addr(a);
    nib(4'hF, q, oe);
    chk("oe_dummy0", {7'd0, oe}, 8'h00);
    nib(4'hF, q, oe);
    chk("oe_dummy1", {7'd0, oe}, 8'h00);
    for (int i = 0; i < n; i++) begin
      nib(4'h0, hi, oe_h);
      nib(4'h0, lo, oe_l);
      idx = a[7:0] + 8'(i);
      chk("rd_byte", {hi, lo}, ref_mem[idx]);
      chk("rd_oe", {6'd0, oe_h, oe_l}, 8'h03);
    end
    txn_end();
    $display("read  addr=%06h bytes=%0d", a, n);
  endtask

  initial begin
    logic [3:0]  q;
    logic        oe;
    logic [23:0] ra [6];
    int          rn [6];

    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

    // Reset state.
    repeat (3) @(negedge gck);
    rst = 1'b0;
    @(negedge gck);
    chk("rst_sio", {4'h0, sio_out}, 8'h00);
    chk("rst_oe", {7'd0, sio_oe}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    do_read(24'h000010, 2);

    // Fill some memory, then reset in the middle of an address phase.
    wq = {};
    for (int i = 0; i < 4; i++) wq.push_back(8'($urandom_range(1, 255)));
    do_write(24'h00000E);
    do_read(24'h00000E, 4);
    txn_start();
    send_byte(8'h02);
    send_byte(8'h00);
    nib(4'h0, q, oe);
    rst = 1'b1;
    @(negedge gck);
    chk("midrst_sio", {4'h0, sio_out}, 8'h00);
    chk("midrst_oe", {7'd0, sio_oe}, 8'h00);
    chk("midrst_busy", {7'd0, busy}, 8'h00);
    sck = 1'b0;
    cs  = 1'b1;
    @(negedge gck);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    repeat (2) @(negedge gck);
    $display("reset during address phase");
    do_read(24'h000010, 1);
    do_read(24'h00000E, 4);

    // Basic write then read.
    wq = {8'hA5, 8'h3C};
    do_write(24'h000010);
    do_read(24'h000010, 2);

    // Address wrap; upper address bits are ignored.
    wq = {8'h11, 8'h22};
    do_write(24'h0123FF);
    do_read(24'h0000FF, 2);
    do_read(24'hABCDFF, 1);
    do_read(24'h000000, 1);

    // Unknown opcode followed by 20 nibbles.
    txn_start();
    send_byte(8'h9F);
    for (int i = 0; i < 20; i++) begin
      nib(4'($urandom), q, oe);
      chk("ign_oe", {7'd0, oe}, 8'h00);
      chk("ign_busy", {7'd0, busy}, 8'h01);
    end
    txn_end();
    $display("unknown opcode 9F with 20 nibbles");
    do_read(24'h0000FE, 4);
    do_read(24'h000010, 2);

    // Aborted write after one data nibble.
    wq = {8'h5A};
    do_write(24'h000020);
    txn_start();
    send_byte(8'h02);
    send_addr(24'h000020);
    nib(4'hC, q, oe);
    txn_end();
    $display("aborted write at 000020");
    do_read(24'h000020, 1);

    // Random transactions at mixed sck rates.
    for (int t = 0; t < 6; t++) begin
      ph = $urandom_range(2, 4);
      ra[t] = 24'($urandom);
      rn[t] = $urandom_range(1, 5);
      wq = {};
      for (int i = 0; i < rn[t]; i++) wq.push_back(8'($urandom));
      do_write(ra[t]);
    end
    for (int t = 0; t < 6; t++) begin
      ph = $urandom_range(2, 4);
      do_read(ra[t], rn[t]);
    end

    // Minimum sck timing with 8 back-to-back bytes.
    ph = 2;
    ra[0] = 24'($urandom);
    wq = {};
    for (int i = 0; i < 8; i++) wq.push_back(8'($urandom));
    do_write(ra[0]);
    do_read(ra[0], 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
